// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer_if
// Purpose  : Control, chart-write and note-output bundle for note_sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface note_sequencer_if #(
    parameter int LANES = 5,
    parameter int DEPTH = 256,
    parameter int DIV_W = 24
);
    localparam int AW = $clog2(DEPTH);

    logic              start;
    logic              stop;
    logic              mode;
    logic              loop_en;
    logic [DIV_W-1:0]  beat_div;
    logic [AW:0]       chart_len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [LANES-1:0]  wr_data;
    logic [LANES-1:0]  lane_activate;
    logic              note_valid;
    logic              busy;
    logic              done;
    logic [AW-1:0]     play_addr;

    modport master (
        output start, stop, mode, loop_en, beat_div, chart_len,
               wr_en, wr_addr, wr_data,
        input  lane_activate, note_valid, busy, done, play_addr
    );

    modport slave (
        input  start, stop, mode, loop_en, beat_div, chart_len,
               wr_en, wr_addr, wr_data,
        output lane_activate, note_valid, busy, done, play_addr
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Purpose  : Beat-timed lane sequencer playing a stored chart or LFSR notes.
// Revision : 1.0  initial release
// ============================================================================
module note_sequencer #(
    parameter int          LANES = 5,
    parameter int          DEPTH = 256,
    parameter int          DIV_W = 24,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  wire logic            Clk,
    input  wire logic            RESET,
    note_sequencer_if.slave      bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [0:0]  c_S_IDLE = 1'b0;
    localparam logic [0:0]  c_S_PLAY = 1'b1;
    localparam logic [AW:0] c_DEPTH  = DEPTH[AW:0];
    localparam logic [15:0] c_TAPS   = 16'hB400;

    logic [LANES-1:0] r_mem [DEPTH];

    logic [0:0]       r_state, w_state_next;
    logic             r_mode, r_loop, r_end, r_valid, r_done;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [AW:0]      r_len, w_len;
    logic [AW-1:0]    r_idx, w_idx_next, r_play_addr;
    logic [LANES-1:0] r_lane, r_rdata, w_rand;
    logic [15:0]      r_lfsr, w_lfsr_next;
    logic             w_busy, w_start, w_beat, w_finish, w_clear, w_wr_ok, w_last;

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) r_state <= c_S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (bus.start)            w_state_next = c_S_PLAY;
            c_S_PLAY: if (bus.stop || r_end)    w_state_next = c_S_IDLE;
            default:                            w_state_next = c_S_IDLE;
        endcase
    end

    // r_end marks the cycle after the final beat; stop takes priority over it
    always_comb begin
        w_busy   = (r_state == c_S_PLAY);
        w_start  = (r_state == c_S_IDLE) && bus.start;
        w_wr_ok  = (r_state == c_S_IDLE) && bus.wr_en;
        w_beat   = w_busy && !bus.stop && !r_end && (r_cnt == r_div);
        w_finish = w_busy && !bus.stop && r_end;
        w_clear  = w_busy && (bus.stop || r_end);
    end

    always_comb begin
        w_len = bus.chart_len;
        if (bus.chart_len == '0 || bus.chart_len > c_DEPTH) w_len = c_DEPTH;
    end

    always_comb begin
        w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
        w_rand      = '0;
        if (32'(r_lfsr[2:0]) < LANES) w_rand = LANES'(1'b1) << r_lfsr[2:0];
        w_idx_next  = r_idx;
        if (!w_busy || w_clear) w_idx_next = '0;
        else if (w_beat)        w_idx_next = w_last ? '0 : r_idx + 1'b1;
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            r_mode      <= 1'b0;
            r_loop      <= 1'b0;
            r_div       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_end       <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_lane      <= '0;
            r_play_addr <= '0;
            r_lfsr      <= SEED;
        end else begin
            r_valid <= w_beat;
            r_done  <= w_finish;
            r_idx   <= w_idx_next;
            r_end   <= w_beat && w_last && !r_loop;
            if (w_start) begin
                r_mode <= bus.mode;
                r_loop <= bus.loop_en;
                r_div  <= bus.beat_div;
                r_len  <= w_len;
                r_cnt  <= '0;
            end else if (w_busy) begin
                if (w_clear || r_cnt == r_div) r_cnt <= '0;
                else                           r_cnt <= r_cnt + 1'b1;
            end
            if (w_clear) begin
                r_lane <= '0;
            end else if (w_beat) begin
                r_lane      <= r_mode ? w_rand : r_rdata;
                r_play_addr <= r_idx;
                if (r_mode) r_lfsr <= w_lfsr_next;
            end
        end
    end

    // r_rdata always holds the entry the next beat will emit; a same-cycle
    // write to that entry is forwarded so start+write returns the new data
    always_ff @(posedge Clk) begin
        if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
        if (w_wr_ok && bus.wr_addr == w_idx_next) r_rdata <= bus.wr_data;
        else                                      r_rdata <= r_mem[w_idx_next];
    end

    assign bus.lane_activate = r_lane;
    assign bus.note_valid    = r_valid;
    assign bus.busy          = w_busy;
    assign bus.done          = r_done;
    assign bus.play_addr     = r_play_addr;

endmodule
`default_nettype wire
